// File: rtl/peri_pwm_capture.sv
// peri_pwm_capture
//   Wishbone peripheral that measures an incoming PWM waveform. It reports the
//   period, the high time and an 8-bit duty value duty = floor(256*high/period),
//   which uses the same encoding the PWM channel accepts.
//
// Ports
//   clk_i     in   1     system clock
//   rst_ni    in   1     asynchronous active-low reset
//   wb_stb_i  in   1     Wishbone strobe (cycle already qualified)
//   wb_we_i   in   1     Wishbone write enable (writes are acked, no effect)
//   wb_adr_i  in   2     register select: 0 duty, 1 high, 2 period, 3 status
//   wb_dat_i  in   8     Wishbone write data (unused)
//   wb_dat_o  out  CntW  Wishbone read data, zero-extended
//   wb_ack_o  out  1     Wishbone acknowledge (same cycle as strobe)
//   pwm_i     in   1     asynchronous PWM input
//
// Divider FSM
//   state  | meaning
//   S_IDLE | no divide running
//   S_DIV  | producing one quotient bit per clk, MSB first
//   S_DONE | quotient complete, written to duty_q on this edge
module peri_pwm_capture #(
    parameter int CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [1:0]      wb_adr_i,
    input  logic [7:0]      wb_dat_i,
    output logic [CntW-1:0] wb_dat_o,
    output logic            wb_ack_o,
    input  logic            pwm_i
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    localparam logic [CntW-1:0] CntMax = '1;

    logic            r_sync1, r_s, r_s_d;
    logic [CntW-1:0] r_per_cnt, r_hi_cnt;
    logic [CntW-1:0] r_period_q, r_high_q, r_rem;
    logic [7:0]      r_duty_q, r_q;
    logic [2:0]      r_idx;
    logic            r_armed, r_valid, r_stale, r_ovr;
    state_t          r_state;

    logic            w_rise, w_timeout, w_capture, w_busy, w_stat_rd;
    logic [CntW:0]   w_rem2, w_diff;
    logic            w_unused;

    assign w_rise    = r_s & ~r_s_d;
    // Saturated period counter without a new edge means the line is stuck.
    assign w_timeout = ~w_rise & (r_per_cnt == CntMax);
    assign w_capture = w_rise & r_armed;
    assign w_busy    = (r_state != S_IDLE);
    assign w_stat_rd = wb_stb_i & ~wb_we_i & (wb_adr_i == 2'd3);
    assign w_rem2    = {r_rem, 1'b0};
    assign w_diff    = w_rem2 - {1'b0, r_period_q};
    assign w_unused  = ^wb_dat_i;

    // Synchroniser, counters, captured values and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1    <= 1'b0;
            r_s        <= 1'b0;
            r_s_d      <= 1'b0;
            r_per_cnt  <= '0;
            r_hi_cnt   <= '0;
            r_period_q <= '0;
            r_high_q   <= '0;
            r_armed    <= 1'b0;
            r_valid    <= 1'b0;
            r_stale    <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync1 <= pwm_i;
            r_s     <= r_sync1;
            r_s_d   <= r_s;

            if (w_rise) begin
                r_per_cnt <= CntW'(1);
                r_hi_cnt  <= CntW'(1);
            end else begin
                if (r_per_cnt != CntMax)
                    r_per_cnt <= r_per_cnt + CntW'(1);
                if (r_s && (r_hi_cnt != CntMax))
                    r_hi_cnt <= r_hi_cnt + CntW'(1);
            end

            if (w_capture) begin
                r_period_q <= r_per_cnt;
                r_high_q   <= r_hi_cnt;
            end

            if (w_timeout)
                r_armed <= 1'b0;
            else if (w_rise)
                r_armed <= 1'b1;

            if (w_timeout)
                r_stale <= 1'b1;
            else if (w_capture)
                r_stale <= 1'b0;

            // Set has priority over the read-to-clear of the status register.
            if (w_capture)
                r_valid <= 1'b1;
            else if (w_stat_rd)
                r_valid <= 1'b0;

            if (w_capture && w_busy)
                r_ovr <= 1'b1;
            else if (w_stat_rd)
                r_ovr <= 1'b0;
        end
    end

    // Restoring divider: q = floor(256*high/period). The capture edge loads the
    // dividend straight from the counter so duty_q lands 9 clk after capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_q      <= '0;
            r_idx    <= '0;
            r_duty_q <= '0;
        end else if (w_timeout) begin
            r_state  <= S_IDLE;
            r_duty_q <= {8{r_s}};
        end else if (w_capture) begin
            r_state <= S_DIV;
            r_rem   <= r_hi_cnt;
            r_q     <= '0;
            r_idx   <= 3'd7;
        end else begin
            case (r_state)
                S_DIV: begin
                    if (w_rem2 >= {1'b0, r_period_q}) begin
                        r_rem        <= w_diff[CntW-1:0];
                        r_q[r_idx]   <= 1'b1;
                    end else begin
                        r_rem <= w_rem2[CntW-1:0];
                    end
                    if (r_idx == 3'd0)
                        r_state <= S_DONE;
                    else
                        r_idx <= r_idx - 3'd1;
                end
                S_DONE: begin
                    r_duty_q <= r_q;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb_ack_o = wb_stb_i;

    always_comb begin
        wb_dat_o = '0;
        case (wb_adr_i)
            2'd0: wb_dat_o = {{(CntW-8){1'b0}}, r_duty_q};
            2'd1: wb_dat_o = r_high_q;
            2'd2: wb_dat_o = r_period_q;
            2'd3: wb_dat_o = {{(CntW-3){1'b0}}, r_ovr, r_stale, r_valid};
            default: wb_dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_peri_pwm_capture.sv
// Directed bench for peri_pwm_capture, built with CntW=10 so timeouts take
// 1023 clk. Expected values are hand-computed from duty = floor(256*high/period).
module tb_peri_pwm_capture;

    localparam int CntW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stb = 1'b0;
    logic            we = 1'b0;
    logic [1:0]      adr = 2'd0;
    logic [7:0]      wdat = 8'd0;
    logic [CntW-1:0] rdat;
    logic            ack;
    logic            pwm = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    peri_pwm_capture #(.CntW(CntW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .pwm_i    (pwm)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        stb = 1'b1;
        we  = 1'b0;
        adr = a;
        #1;
        check({tag, "_ack"}, 16'(ack), 16'd1);
        check(tag, 16'(rdat), exp);
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input string tag);
        @(negedge clk);
        stb  = 1'b1;
        we   = 1'b1;
        adr  = a;
        wdat = 8'hFF;
        #1;
        check(tag, 16'(ack), 16'd1);
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic pwm_run(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            pwm = 1'b1;
            repeat (hi) @(negedge clk);
            pwm = 1'b0;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    initial begin
        // Reset values while held in reset
        idle(3);
        #1;
        check("rst_ack", 16'(ack), 16'd0);
        adr = 2'd0; #1; check("rst_duty",   16'(rdat), 16'h0);
        adr = 2'd1; #1; check("rst_high",   16'(rdat), 16'h0);
        adr = 2'd2; #1; check("rst_period", 16'(rdat), 16'h0);
        adr = 2'd3; #1; check("rst_status", 16'(rdat), 16'h0);
        idle(1);
        rst_n = 1'b1;

        // 1: line low after reset -> stale with duty 0x00
        rd(2'd3, 16'h0, "t1_status0");
        rd(2'd0, 16'h0, "t1_duty0");
        idle(1030);
        rd(2'd3, 16'h2, "t1_stale");
        rd(2'd0, 16'h0, "t1_duty_low");

        // 2: period 40, high 10 -> duty 0x40; writes have no effect
        pwm_run(40, 10, 3);
        idle(12);
        wr(2'd3, "t2_wr_ack");
        rd(2'd2, 16'd40,  "t2_period");
        rd(2'd1, 16'd10,  "t2_high");
        rd(2'd0, 16'h40,  "t2_duty");
        rd(2'd3, 16'h1,   "t2_status");
        rd(2'd3, 16'h0,   "t2_status_clr");

        // 3: 256*299/300 = 255.1 -> 0xFF; 256*298/300 = 254.3 -> 0xFE; 256/3 -> 0x55
        pwm_run(300, 299, 3);
        idle(20);
        rd(2'd0, 16'hFF,  "t3_duty_299");
        rd(2'd1, 16'd299, "t3_high_299");
        rd(2'd2, 16'd300, "t3_period_300");
        pwm_run(300, 298, 3);
        idle(20);
        rd(2'd0, 16'hFE,  "t3_duty_298");
        pwm_run(3, 1, 10);
        idle(20);
        rd(2'd0, 16'h55,  "t3_duty_3_1");
        rd(2'd2, 16'd3,   "t3_period_3");
        rd(2'd3, 16'h5,   "t3_status_ovr");

        // 4: stuck high -> stale, duty 0xFF; two rises recover
        pwm = 1'b1;
        idle(1030);
        rd(2'd3, 16'h3,   "t4_stale_hi");
        rd(2'd0, 16'hFF,  "t4_duty_hi");
        pwm = 1'b0;
        idle(5);
        pwm_run(20, 10, 2);
        idle(10);
        rd(2'd3, 16'h1,   "t4_recover_status");
        rd(2'd2, 16'd20,  "t4_period");
        rd(2'd1, 16'd10,  "t4_high");
        rd(2'd0, 16'h80,  "t4_duty");

        // 5: period 4 overruns the divider; final divide still gives 0x40
        pwm_run(4, 1, 10);
        idle(15);
        rd(2'd0, 16'h40,  "t5_duty");
        rd(2'd3, 16'h5,   "t5_ovr_set");
        rd(2'd3, 16'h0,   "t5_ovr_clr");

        // 6: reset while dividing
        rd(2'd0, 16'h40,  "t6_duty_before");
        pwm = 1'b1;
        idle(6);
        rst_n = 1'b0;
        #1;
        adr = 2'd0; #1; check("t6_rst_duty",   16'(rdat), 16'h0);
        adr = 2'd2; #1; check("t6_rst_period", 16'(rdat), 16'h0);
        adr = 2'd3; #1; check("t6_rst_status", 16'(rdat), 16'h0);
        check("t6_rst_ack", 16'(ack), 16'd0);
        idle(3);
        rst_n = 1'b1;
        idle(10);
        pwm = 1'b0;
        idle(20);
        rd(2'd3, 16'h0,   "t6_unarmed_status");
        rd(2'd2, 16'h0,   "t6_unarmed_period");
        rd(2'd0, 16'h0,   "t6_unarmed_duty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
